conv_sram_arbiter: RTL

CONV_SRAM_ARBITER -- requirements
Module: conv_sram_arbiter

---
 rtl/conv_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_sram_arbiter.sv
//------------------------------------------------------------------------------
// conv_sram_arbiter
//
// Purpose:
//   Shares one single-port pixel SRAM between two clients of a convolution
//   pipeline:
//     - a Gaussian-filter writer, whose writes are posted into a small FIFO
//       (write buffer) and drained to the SRAM one entry per grant;
//     - a FAST-detector reader, which is granted directly and gets its pixel
//       back one cycle after the grant.
//   When both clients have a candidate in the same cycle, the one that did
//   not win the previous grant wins (1-bit round robin).  A read whose
//   address matches any write still sitting in the buffer is held off until
//   those writes have reached the SRAM, so the reader never sees stale data
//   for a location it has already been told about.
//
// Parameters:
//   X_MAX, Y_MAX   image width / height bounds (set coordinate widths)
//   PIXEL_DEPTH    pixel width in bits
//   WBUF_DEPTH     write buffer entries, power of two, at least 2
//
// Ports:
//   clk          single clock, rising edge
//   n_rst        synchronous active-low reset; all outputs forced to 0 while low
//   flush        synchronous clear of buffer, round robin and read-valid state
//   wr_valid     write request            wr_ready   write accepted this cycle
//   wr_x/wr_y    write coordinates        wr_data    write pixel
//   rd_valid     read request             rd_ready   read granted this cycle
//   rd_x/rd_y    read coordinates
//   rd_rvalid    read data valid (registered, one cycle after grant)
//   rd_rdata     read pixel, sram_rdat while rd_rvalid, else 0
//   sram_x/y     SRAM address             sram_ren / sram_wen   SRAM enables
//   sram_wdat    SRAM write data          sram_rdat  SRAM read data (+1 cycle)
//   wbuf_count   number of buffered writes
//   busy         high while the write buffer is non-empty
//------------------------------------------------------------------------------
module conv_sram_arbiter #(
    parameter  int X_MAX       = 400,
    parameter  int Y_MAX       = 400,
    parameter  int PIXEL_DEPTH = 8,
    parameter  int WBUF_DEPTH  = 4,
    localparam int XW          = $clog2(X_MAX) + 1,
    localparam int YW          = $clog2(Y_MAX) + 1,
    localparam int CW          = $clog2(WBUF_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   flush,
    // Gaussian write port
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [XW-1:0]          wr_x,
    input  logic [YW-1:0]          wr_y,
    input  logic [PIXEL_DEPTH-1:0] wr_data,
    // FAST read port
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [XW-1:0]          rd_x,
    input  logic [YW-1:0]          rd_y,
    output logic                   rd_rvalid,
    output logic [PIXEL_DEPTH-1:0] rd_rdata,
    // SRAM port
    output logic [XW-1:0]          sram_x,
    output logic [YW-1:0]          sram_y,
    output logic                   sram_ren,
    output logic                   sram_wen,
    output logic [PIXEL_DEPTH-1:0] sram_wdat,
    input  logic [PIXEL_DEPTH-1:0] sram_rdat,
    // Status
    output logic [CW-1:0]          wbuf_count,
    output logic                   busy
);

    // Pointer width; pointers wrap naturally because WBUF_DEPTH is a power of two.
    localparam int PW = $clog2(WBUF_DEPTH);

    //--------------------------------------------------------------------------
    // Helpers
    //--------------------------------------------------------------------------

    // True when two pixel coordinates name the same SRAM location.
    function automatic logic f_addr_match(
        input logic [XW-1:0] ax,
        input logic [YW-1:0] ay,
        input logic [XW-1:0] bx,
        input logic [YW-1:0] by
    );
        return (ax == bx) && (ay == by);
    endfunction

    // True when slot 'slot' currently holds a buffered write: its distance
    // from the read pointer (modulo depth) is below the occupancy count.
    function automatic logic f_slot_valid(
        input logic [PW-1:0] slot,
        input logic [PW-1:0] rptr,
        input logic [CW-1:0] count
    );
        logic [PW-1:0] ofs;
        ofs = slot - rptr;
        return (CW'(ofs) < count);
    endfunction

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [XW-1:0]          r_fifo_x [WBUF_DEPTH];
    logic [YW-1:0]          r_fifo_y [WBUF_DEPTH];
    logic [PIXEL_DEPTH-1:0] r_fifo_d [WBUF_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_last_grant;   // 0 = write won last, 1 = read won last
    logic                   r_rd_rvalid;

    //--------------------------------------------------------------------------
    // Decode
    //--------------------------------------------------------------------------
    logic                   w_full;
    logic                   w_wr_ready;
    logic                   w_push;
    logic [WBUF_DEPTH-1:0]  w_slot_hit;
    logic                   w_hazard;
    logic                   w_wr_cand;
    logic                   w_rd_cand;
    logic                   w_gnt_wr;
    logic                   w_gnt_rd;

    // Acceptance is decoded from the registered count only, so an entry pushed
    // this cycle can reach the SRAM no earlier than the next cycle.
    assign w_full     = (r_count == CW'(WBUF_DEPTH));
    assign w_wr_ready = n_rst & ~flush & ~w_full;
    assign w_push     = wr_valid & w_wr_ready;

    // Per-slot read-after-write hazard detection against buffered writes.
    always_comb begin
        w_slot_hit = {WBUF_DEPTH{1'b0}};
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            w_slot_hit[i] = f_slot_valid(PW'(i), r_rptr, r_count) &
                            f_addr_match(r_fifo_x[i], r_fifo_y[i], rd_x, rd_y);
        end
    end

    assign w_hazard  = |w_slot_hit;
    assign w_wr_cand = n_rst & ~flush & (r_count != {CW{1'b0}});
    assign w_rd_cand = n_rst & ~flush & rd_valid & ~w_hazard;

    // Grant selection: a lone candidate always wins; on contention the
    // requester that did not win the previous grant goes first.
    always_comb begin
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        case ({w_wr_cand, w_rd_cand})
            2'b11: begin
                if (r_last_grant) begin
                    w_gnt_wr = 1'b1;
                end else begin
                    w_gnt_rd = 1'b1;
                end
            end
            2'b10: w_gnt_wr = 1'b1;
            2'b01: w_gnt_rd = 1'b1;
            default: begin
                w_gnt_wr = 1'b0;
                w_gnt_rd = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // SRAM and client-side outputs
    //--------------------------------------------------------------------------

    // SRAM command mux: head of the write buffer, the read address, or all zero.
    always_comb begin
        sram_ren  = 1'b0;
        sram_wen  = 1'b0;
        rd_ready  = 1'b0;
        sram_x    = {XW{1'b0}};
        sram_y    = {YW{1'b0}};
        sram_wdat = {PIXEL_DEPTH{1'b0}};
        if (w_gnt_wr) begin
            sram_wen  = 1'b1;
            sram_x    = r_fifo_x[r_rptr];
            sram_y    = r_fifo_y[r_rptr];
            sram_wdat = r_fifo_d[r_rptr];
        end else if (w_gnt_rd) begin
            sram_ren  = 1'b1;
            rd_ready  = 1'b1;
            sram_x    = rd_x;
            sram_y    = rd_y;
            sram_wdat = {PIXEL_DEPTH{1'b0}};
        end else begin
            sram_ren  = 1'b0;
            sram_wen  = 1'b0;
            rd_ready  = 1'b0;
            sram_x    = {XW{1'b0}};
            sram_y    = {YW{1'b0}};
            sram_wdat = {PIXEL_DEPTH{1'b0}};
        end
    end

    // Status and read-return outputs are gated by n_rst so that every output
    // is zero while reset is held, including the first reset cycle before the
    // registers have been cleared by a clock edge.
    assign wr_ready   = w_wr_ready;
    assign wbuf_count = n_rst ? r_count : {CW{1'b0}};
    assign busy       = n_rst & (r_count != {CW{1'b0}});
    assign rd_rvalid  = n_rst & r_rd_rvalid;
    assign rd_rdata   = (n_rst & r_rd_rvalid) ? sram_rdat : {PIXEL_DEPTH{1'b0}};

    //--------------------------------------------------------------------------
    // Sequential logic
    //--------------------------------------------------------------------------

    // Write buffer storage; only slots covered by the count are ever consumed,
    // so the payload itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_x[r_wptr] <= wr_x;
            r_fifo_y[r_wptr] <= wr_y;
            r_fifo_d[r_wptr] <= wr_data;
        end
    end

    // Buffer pointers, occupancy, round-robin history and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wptr       <= {PW{1'b0}};
            r_rptr       <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_last_grant <= 1'b0;
            r_rd_rvalid  <= 1'b0;
        end else if (flush) begin
            // Flush drops every buffered write and any read result in flight.
            r_wptr       <= {PW{1'b0}};
            r_rptr       <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_last_grant <= 1'b0;
            r_rd_rvalid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end else begin
                r_wptr <= r_wptr;
            end

            if (w_gnt_wr) begin
                r_rptr <= r_rptr + PW'(1);
            end else begin
                r_rptr <= r_rptr;
            end

            // Push and pop in the same cycle leave the occupancy unchanged.
            case ({w_push, w_gnt_wr})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_gnt_wr | w_gnt_rd) begin
                r_last_grant <= w_gnt_rd;
            end else begin
                r_last_grant <= r_last_grant;
            end

            r_rd_rvalid <= w_gnt_rd;
        end
    end

endmodule
